// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines x 4 words.
// Memory traffic is whole lines; the processor address is held stable while stalled.
module dcache_wb (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  // COMPARE: serve hits / detect misses; WRITEBACK: evict dirty victim;
  // ALLOCATE: fetch line; REFILL: one settle cycle before the retried hit.
  typedef enum logic [1:0] {
    S_COMPARE   = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2,
    S_REFILL    = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [7:0]   valid_q;
  logic [7:0]   dirty_q;
  logic [24:0]  tag_q  [8];
  logic [31:0]  data_q [8][4];

  logic [2:0]   idx;
  logic [24:0]  tag;
  logic [1:0]   off;
  logic         req;
  logic         hit;
  logic         write_hit;
  logic         fill;
  logic         clr_dirty;

  assign idx = proc_addr[4:2];
  assign tag = proc_addr[29:5];
  assign off = proc_addr[1:0];
  assign req = proc_read | proc_write;
  assign hit = valid_q[idx] && (tag_q[idx] == tag) && req;

  always_comb begin
    state_d    = state_q;
    proc_stall = 1'b0;
    proc_rdata = 32'd0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = 28'd0;
    mem_wdata  = 128'd0;
    write_hit  = 1'b0;
    fill       = 1'b0;
    clr_dirty  = 1'b0;
    unique case (state_q)
      S_COMPARE: begin
        if (hit) begin
          if (proc_read) proc_rdata = data_q[idx][off];
          write_hit = proc_write;
        end else if (req) begin
          proc_stall = 1'b1;
          state_d    = (valid_q[idx] && dirty_q[idx]) ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {tag_q[idx], idx};
        mem_wdata  = {data_q[idx][3], data_q[idx][2], data_q[idx][1], data_q[idx][0]};
        if (mem_ready) begin
          clr_dirty = 1'b1;
          state_d   = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = proc_addr[29:2];
        if (mem_ready) begin
          fill    = 1'b1;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        proc_stall = 1'b1;
        state_d    = S_COMPARE;
      end
      default: state_d = S_COMPARE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q <= S_COMPARE;
      valid_q <= 8'd0;
      dirty_q <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        tag_q[i] <= 25'd0;
        for (int j = 0; j < 4; j++) data_q[i][j] <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      if (write_hit) begin
        data_q[idx][off] <= proc_wdata;
        dirty_q[idx]     <= 1'b1;
      end
      if (clr_dirty) dirty_q[idx] <= 1'b0;
      if (fill) begin
        for (int w = 0; w < 4; w++) data_q[idx][w] <= mem_rdata[w*32 +: 32];
        tag_q[idx]   <= tag;
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dcache_wb.sv
// Self-checking bench for dcache_wb: directed scenarios plus random traffic
// compared against an array-based cache/memory model.
module tb_dcache_wb;

  logic         clk;
  logic         proc_reset;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  dcache_wb dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // reference model: cache contents plus a line-addressed backing memory
  logic         m_valid [8];
  logic         m_dirty [8];
  logic [24:0]  m_tag   [8];
  logic [31:0]  m_data  [8][4];
  logic [127:0] memory  [logic [27:0]];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] m_line(input logic [2:0] ix);
    return {m_data[ix][3], m_data[ix][2], m_data[ix][1], m_data[ix][0]};
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = 25'd0;
      for (int j = 0; j < 4; j++) m_data[i][j] = 32'd0;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_stall"}, proc_stall, 0);
    check({tag, "_mrd"},   mem_read,   0);
    check({tag, "_mwr"},   mem_write,  0);
    check({tag, "_maddr"}, mem_addr,   0);
    check({tag, "_mwd"},   mem_wdata,  0);
    check({tag, "_rdata"}, proc_rdata, 0);
  endtask

  // Called at the negedge of the first WRITEBACK/ALLOCATE cycle; returns at
  // the negedge of the cycle after mem_ready was accepted.
  task automatic mem_wait(input bit is_wr, input logic [27:0] exp_addr,
                          input logic [127:0] exp_wdata, input logic [127:0] rdata,
                          input int lat);
    for (int c = 0; c <= lat; c++) begin
      if (c > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      check(is_wr ? "wb_mwr"   : "al_mwr",   mem_write,  is_wr);
      check(is_wr ? "wb_mrd"   : "al_mrd",   mem_read,   !is_wr);
      check(is_wr ? "wb_maddr" : "al_maddr", mem_addr,   exp_addr);
      check(is_wr ? "wb_stall" : "al_stall", proc_stall, 1);
      if (is_wr) check("wb_mwdata", mem_wdata, exp_wdata);
    end
    mem_rdata = rdata;
    mem_ready = 1'b1;
    @(posedge clk);
    #1 mem_ready = 1'b0;
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
  endtask

  task automatic do_req(input bit wr, input logic [29:0] a, input logic [31:0] wd, input int lat);
    logic [2:0]  ix = a[4:2];
    logic [24:0] tg = a[29:5];
    logic [1:0]  of = a[1:0];
    logic [27:0] la = a[29:2];
    logic [27:0] wa;
    @(posedge clk);
    #1;
    proc_read  = !wr;
    proc_write = wr;
    proc_addr  = a;
    proc_wdata = wd;
    @(negedge clk);
    if (!(m_valid[ix] && m_tag[ix] == tg)) begin
      check("miss_stall", proc_stall, 1);
      check("miss_memreq", {mem_read, mem_write}, 0);
      @(posedge clk);
      @(negedge clk);
      if (m_dirty[ix]) begin
        wa = {m_tag[ix], ix};
        mem_wait(1'b1, wa, m_line(ix), 128'd0, lat);
        memory[wa] = m_line(ix);
        m_dirty[ix] = 1'b0;
      end
      if (!memory.exists(la)) memory[la] = {$urandom, $urandom, $urandom, $urandom};
      mem_wait(1'b0, la, 128'd0, memory[la], lat);
      for (int w = 0; w < 4; w++) m_data[ix][w] = memory[la][w*32 +: 32];
      m_tag[ix]   = tg;
      m_valid[ix] = 1'b1;
      m_dirty[ix] = 1'b0;
      check("refill_stall", proc_stall, 1);
      check("refill_memreq", {mem_read, mem_write}, 0);
      @(posedge clk);
      @(negedge clk);
    end
    check("hit_stall", proc_stall, 0);
    check("hit_memreq", {mem_read, mem_write}, 0);
    if (wr) begin
      check("wr_rdata_zero", proc_rdata, 0);
      m_data[ix][of] = wd;
      m_dirty[ix]    = 1'b1;
    end else begin
      check("rd_rdata", proc_rdata, m_data[ix][of]);
    end
  endtask

  initial begin
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = 30'd0;
    proc_wdata = 32'd0;
    mem_rdata  = 128'd0;
    mem_ready  = 1'b0;
    reset_model();

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("in_reset");
    @(posedge clk);
    #1 proc_reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");

    // cold read, write hit, read back, dirty eviction, clean eviction
    memory[28'h0000004] = {32'h0, 32'h0, 32'h0, 32'h11223344};
    do_req(1'b0, 30'h0000010, 32'h0, 3);
    do_req(1'b1, 30'h0000011, 32'hDEADBEEF, 0);
    do_req(1'b0, 30'h0000011, 32'h0, 0);
    do_req(1'b0, 30'h0000030, 32'h0, 1);
    check("evicted_word1", memory[28'h0000004][63:32], 32'hDEADBEEF);
    do_req(1'b0, 30'h0000010, 32'h0, 2);

    // stray mem_ready while idle
    @(posedge clk);
    #1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    mem_ready  = 1'b1;
    @(posedge clk);
    #1 mem_ready = 1'b0;
    @(negedge clk);
    check_idle_outputs("stray_ready");
    do_req(1'b0, 30'h0000012, 32'h0, 0);

    // reset in the middle of ALLOCATE
    do_req(1'b0, 30'h0000100, 32'h0, 1);
    @(posedge clk);
    #1;
    proc_read  = 1'b1;
    proc_write = 1'b0;
    proc_addr  = 30'h0000200;
    @(negedge clk);
    check("ra_miss_stall", proc_stall, 1);
    @(posedge clk);
    @(negedge clk);
    check("ra_mrd", mem_read, 1);
    proc_reset = 1'b1;
    mem_ready  = 1'b1;
    proc_read  = 1'b0;
    @(posedge clk);
    #1;
    proc_reset = 1'b0;
    mem_ready  = 1'b0;
    @(negedge clk);
    check_idle_outputs("ra_after");
    reset_model();
    do_req(1'b0, 30'h0000100, 32'h0, 0);

    // random traffic over a few tags to force conflicts
    for (int t = 0; t < 300; t++) begin
      logic [29:0] a;
      a = {23'd0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      do_req(($urandom_range(0, 9) < 4), a, $urandom, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
